// File: rtl/nn_weight_load_if.sv
// Handshake bundle between the weight source / FIFO bank side and the weight load controller.
// The controller connects through the slave modport; the source/bank side uses master.
interface nn_weight_load_if #(
  parameter int N_FIFO = 16,
  parameter int DW     = 8,
  parameter int CNT_W  = 8
);
  localparam int SEL_W = $clog2(N_FIFO);

  logic              start;
  logic [CNT_W-1:0]  num_words;
  logic              w_valid;
  logic [DW-1:0]     w_data;
  logic              w_ready;
  logic [N_FIFO-1:0] fifo_full;
  logic [N_FIFO-1:0] fifo_wr;
  logic [DW-1:0]     fifo_din;
  logic [SEL_W-1:0]  sel;
  logic              busy;
  logic              done;

  modport master (
    output start, num_words, w_valid, w_data, fifo_full,
    input  w_ready, fifo_wr, fifo_din, sel, busy, done
  );

  modport slave (
    input  start, num_words, w_valid, w_data, fifo_full,
    output w_ready, fifo_wr, fifo_din, sel, busy, done
  );
endinterface

// File: rtl/nn_weight_load_ctrl.sv
// Round-robin weight loader: spreads a valid/ready weight stream over N_FIFO weight FIFOs,
// num_words words per FIFO, stalling on the full flag of the FIFO currently targeted.
module nn_weight_load_ctrl #(
  parameter int N_FIFO = 16,
  parameter int DW     = 8,
  parameter int CNT_W  = 8
) (
  input logic            clk,
  input logic            reset_n,
  nn_weight_load_if.slave bus
);
  localparam int SEL_W = $clog2(N_FIFO);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_FIFO - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SEL_W-1:0]  r_sel;
  logic [CNT_W-1:0]  r_pass;
  logic [CNT_W-1:0]  r_num_words;
  logic [N_FIFO-1:0] r_fifo_wr_p1;
  logic [DW-1:0]     r_fifo_din_p1;

  logic w_rdy;
  logic w_accept;
  logic w_last_word;

  // No skip-ahead: only the full flag of the current target matters, so ordering is kept.
  assign w_rdy       = (r_state == S_LOAD) && !bus.fifo_full[r_sel];
  assign w_accept    = w_rdy && bus.w_valid;
  assign w_last_word = (r_sel == SEL_MAX) && (r_pass == (r_num_words - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.num_words == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept && w_last_word) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sel       <= '0;
      r_pass      <= '0;
      r_num_words <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_num_words <= bus.num_words;
      r_sel       <= '0;
      r_pass      <= '0;
    end else if (w_accept) begin
      r_sel <= r_sel + SEL_W'(1);
      if (r_sel == SEL_MAX) begin
        r_pass <= r_pass + CNT_W'(1);
      end
    end
  end

  // Stage p1: write strobe and data registered one cycle after the accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fifo_wr_p1  <= '0;
      r_fifo_din_p1 <= '0;
    end else begin
      r_fifo_wr_p1 <= w_accept ? (N_FIFO'(1) << r_sel) : '0;
      if (w_accept) begin
        r_fifo_din_p1 <= bus.w_data;
      end
    end
  end

  assign bus.w_ready  = w_rdy;
  assign bus.fifo_wr  = r_fifo_wr_p1;
  assign bus.fifo_din = r_fifo_din_p1;
  assign bus.sel      = r_sel;
  assign bus.busy     = (r_state == S_LOAD);
  assign bus.done     = (r_state == S_DONE);

  a_wr_onehot0 : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(r_fifo_wr_p1));
  a_ready_only_in_load : assert property (@(posedge clk) disable iff (!reset_n)
    w_rdy |-> (r_state == S_LOAD));
  a_done_single : assert property (@(posedge clk) disable iff (!reset_n)
    (r_state == S_DONE) |=> (r_state == S_IDLE));
endmodule

// File: tb/tb_nn_weight_load_ctrl.sv
// Directed bench for nn_weight_load_ctrl: a vector table for cycle-exact behaviour plus
// stream sequences checked against an expected write order.
module tb_nn_weight_load_ctrl;
  localparam int N_FIFO = 16;
  localparam int DW     = 8;
  localparam int CNT_W  = 8;

  logic clk;
  logic reset_n;

  nn_weight_load_if #(.N_FIFO(N_FIFO), .DW(DW), .CNT_W(CNT_W)) bus ();

  nn_weight_load_ctrl #(.N_FIFO(N_FIFO), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [7:0]  nw;
    logic        valid;
    logic [7:0]  data;
    logic [15:0] full;
    logic        exp_ready;
    logic [3:0]  exp_sel;
    logic [15:0] exp_wr;
    logic        chk_din;
    logic [7:0]  exp_din;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  typedef struct {
    logic [15:0] wr;
    logic [7:0]  din;
  } wr_t;

  vec_t vecs[$];
  wr_t  wr_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;

  // Passive monitor of the FIFO-side outputs, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.fifo_wr != '0) wr_q.push_back('{wr: bus.fifo_wr, din: bus.fifo_din});
      if (bus.done) done_cnt++;
      if (bus.busy) busy_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit st, input int nw, input bit v, input int d, input int f,
                              input bit er, input int es, input int ew, input bit cd,
                              input int ed, input bit eb, input bit edn);
    vec_t r;
    r.start     = st;
    r.nw        = 8'(nw);
    r.valid     = v;
    r.data      = 8'(d);
    r.full      = 16'(f);
    r.exp_ready = er;
    r.exp_sel   = 4'(es);
    r.exp_wr    = 16'(ew);
    r.chk_din   = cd;
    r.exp_din   = 8'(ed);
    r.exp_busy  = eb;
    r.exp_done  = edn;
    return r;
  endfunction

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.num_words = '0;
    bus.w_valid   = 1'b0;
    bus.w_data    = '0;
    bus.fifo_full = '0;
  endtask

  task automatic clr();
    wr_q.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " fifo_wr"},  32'(bus.fifo_wr),  32'h0);
    check({tag, " fifo_din"}, 32'(bus.fifo_din), 32'h0);
    check({tag, " sel"},      32'(bus.sel),      32'h0);
    check({tag, " busy"},     32'(bus.busy),     32'h0);
    check({tag, " done"},     32'(bus.done),     32'h0);
    check({tag, " w_ready"},  32'(bus.w_ready),  32'h0);
  endtask

  task automatic apply(input vec_t v, input int idx);
    bus.start     = v.start;
    bus.num_words = v.nw;
    bus.w_valid   = v.valid;
    bus.w_data    = v.data;
    bus.fifo_full = v.full;
    #1;
    check($sformatf("row%0d w_ready", idx), 32'(bus.w_ready), 32'(v.exp_ready));
    check($sformatf("row%0d sel", idx),     32'(bus.sel),     32'(v.exp_sel));
    @(posedge clk); #1;
    check($sformatf("row%0d fifo_wr", idx), 32'(bus.fifo_wr), 32'(v.exp_wr));
    if (v.chk_din) check($sformatf("row%0d fifo_din", idx), 32'(bus.fifo_din), 32'(v.exp_din));
    check($sformatf("row%0d busy", idx), 32'(bus.busy), 32'(v.exp_busy));
    check($sformatf("row%0d done", idx), 32'(bus.done), 32'(v.exp_done));
  endtask

  task automatic start_load(input int nw);
    bus.start     = 1'b1;
    bus.num_words = 8'(nw);
    bus.w_valid   = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Word k carries data k; stops on done, on max_acc accepts (if nonzero), or on timeout.
  task automatic run_stream(input string tag, input bit toggle, input bit hold_start,
                            input int max_acc, output int acc);
    bit seen_done = 1'b0;
    bit fire;
    acc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.w_valid   = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.w_data    = 8'(acc);
      bus.start     = hold_start;
      bus.num_words = hold_start ? 8'd5 : 8'd0;
      #1;
      fire = bus.w_valid && bus.w_ready;
      @(posedge clk); #1;
      if (fire) acc++;
      if (bus.done) begin
        seen_done = 1'b1;
        break;
      end
      if (max_acc != 0 && acc == max_acc) break;
    end
    bus.w_valid = 1'b0;
    bus.start   = 1'b0;
    if (max_acc == 0) check({tag, " done_seen"}, 32'(seen_done), 32'h1);
  endtask

  task automatic check_writes(input string tag, input int n_exp);
    check({tag, " write_count"}, 32'(wr_q.size()), 32'(n_exp));
    for (int k = 0; k < wr_q.size() && k < n_exp; k++) begin
      check($sformatf("%s wr%0d strobe", tag, k), 32'(wr_q[k].wr), 32'(16'(1) << (k % N_FIFO)));
      check($sformatf("%s wr%0d data", tag, k),   32'(wr_q[k].din), 32'(8'(k)));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;

    // Walk of 16 writes with continuous valid.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(0, 1, 1, i, 0, 1, i, 1 << i, 1, i, i != 15, i == 15));
    vecs.push_back(mk(0, 1, 1, 'hAA, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 'hAA, 0, 0, 0, 0, 0, 0, 0, 0));
    // Stall on FIFO 5 for four cycles; a full flag on an already-served FIFO is ignored.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1, 1, 'h40 + i, 0, 1, i, 1 << i, 1, 'h40 + i, 1, 0));
    for (int j = 0; j < 4; j++)
      vecs.push_back(mk(0, 1, 1, 'h45, 'h0020, 0, 5, 0, 0, 0, 1, 0));
    for (int i = 5; i < 16; i++)
      vecs.push_back(mk(0, 1, 1, 'h40 + i, 'h0010, 1, i, 1 << i, 1, 'h40 + i, i != 15, i == 15));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    idle_inputs();

    // num_words=3, continuous valid.
    clr();
    start_load(3);
    run_stream("nw3", 1'b0, 1'b0, 0, acc);
    @(posedge clk); #1;
    check("nw3 accepts", 32'(acc), 32'd48);
    check_writes("nw3", 48);
    check("nw3 busy_cycles", 32'(busy_cnt), 32'd48);
    check("nw3 done_pulses", 32'(done_cnt), 32'd1);

    // num_words=2, valid toggling every cycle.
    clr();
    start_load(2);
    run_stream("toggle", 1'b1, 1'b0, 0, acc);
    @(posedge clk); #1;
    check("toggle accepts", 32'(acc), 32'd32);
    check_writes("toggle", 32);
    check("toggle busy_cycles", 32'(busy_cnt), 32'd63);
    check("toggle done_pulses", 32'(done_cnt), 32'd1);

    // num_words=0: straight to DONE with no writes.
    clr();
    bus.start     = 1'b1;
    bus.num_words = 8'd0;
    bus.w_valid   = 1'b1;
    #1;
    check("nw0 w_ready_idle", 32'(bus.w_ready), 32'h0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("nw0 done", 32'(bus.done), 32'h1);
    check("nw0 busy", 32'(bus.busy), 32'h0);
    check("nw0 w_ready_done", 32'(bus.w_ready), 32'h0);
    check("nw0 fifo_wr", 32'(bus.fifo_wr), 32'h0);
    @(posedge clk); #1;
    check("nw0 done_after", 32'(bus.done), 32'h0);
    bus.w_valid = 1'b0;
    check("nw0 writes", 32'(wr_q.size()), 32'd0);
    check("nw0 done_pulses", 32'(done_cnt), 32'd1);

    // Reset after 20 accepts, then a fresh load with start held high during LOAD.
    clr();
    start_load(2);
    run_stream("abort", 1'b0, 1'b0, 20, acc);
    check("abort accepts", 32'(acc), 32'd20);
    reset_n       = 1'b0;
    bus.start     = 1'b1;
    bus.num_words = 8'd3;
    bus.w_valid   = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    check_reset_outputs("midreset2");
    idle_inputs();
    reset_n = 1'b1;
    @(posedge clk); #1;
    clr();
    start_load(1);
    check("reload sel", 32'(bus.sel), 32'h0);
    check("reload busy", 32'(bus.busy), 32'h1);
    run_stream("reload", 1'b0, 1'b1, 0, acc);
    @(posedge clk); #1;
    check("reload idle_busy", 32'(bus.busy), 32'h0);
    check("reload accepts", 32'(acc), 32'd16);
    check_writes("reload", 16);
    check("reload done_pulses", 32'(done_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
